// File: rtl/audio_sampler.sv
// Z80-attached audio capture block: samples an ADC at a fixed tick rate into a 256-entry FIFO
// that the CPU drains through a data port, with a control/status port alongside.
module audio_sampler #(
  parameter logic [7:0]  DATA_PORT = 8'hDF,
  parameter logic [7:0]  CTRL_PORT = 8'hDE,
  parameter int unsigned TICK_DIV  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] d,
  input  logic [7:0] sample_in,
  output logic [7:0] dout,
  output logic       oe
);

  localparam int unsigned    DivW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);

  logic [7:0]      mem [256];
  logic [7:0]      wr_ptr;
  logic [7:0]      rd_ptr;
  logic [8:0]      count;
  logic [DivW-1:0] div;
  logic            enable;
  logic            overflow;
  logic            data_rd_prev;
  logic            ctrl_rd_prev;

  logic tick;
  logic data_rd;
  logic ctrl_rd;
  logic ctrl_wr;
  logic clr;
  logic data_end;
  logic ctrl_end;
  logic empty;
  logic full;
  logic push;
  logic pop;
  logic ovf_set;

  assign tick    = (div == DivMax);
  assign data_rd = !iorq_n && !rd_n && (a == DATA_PORT);
  assign ctrl_rd = !iorq_n && !rd_n && (a == CTRL_PORT);
  assign ctrl_wr = !iorq_n && !wr_n && (a == CTRL_PORT);
  assign clr     = ctrl_wr && d[1];
  assign oe      = data_rd || ctrl_rd;

  assign empty = (count == 9'd0);
  assign full  = count[8];

  // An access completes on the falling edge of its decode term, so a long strobe pops once.
  assign data_end = data_rd_prev && !data_rd;
  assign ctrl_end = ctrl_rd_prev && !ctrl_rd;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept the tick's sample.
  assign pop     = data_end && !empty;
  assign push    = tick && enable && (!full || pop);
  assign ovf_set = tick && enable && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      div          <= '0;
      enable       <= 1'b0;
      overflow     <= 1'b0;
      wr_ptr       <= 8'd0;
      rd_ptr       <= 8'd0;
      count        <= 9'd0;
      data_rd_prev <= 1'b0;
      ctrl_rd_prev <= 1'b0;
    end else begin
      div          <= tick ? '0 : div + 1'b1;
      data_rd_prev <= data_rd;
      ctrl_rd_prev <= ctrl_rd;
      if (ctrl_wr) begin
        enable <= d[0];
      end
      if (clr) begin
        wr_ptr   <= 8'd0;
        rd_ptr   <= 8'd0;
        count    <= 9'd0;
        overflow <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 8'd1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 8'd1;
        end
        if (push && !pop) begin
          count <= count + 9'd1;
        end else if (pop && !push) begin
          count <= count - 9'd1;
        end
        if (ovf_set) begin
          overflow <= 1'b1;
        end else if (ctrl_end) begin
          overflow <= 1'b0;
        end
      end
    end
  end

  // Sample storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= sample_in;
    end
  end

  always_comb begin
    dout = 8'h00;
    if (data_rd) begin
      dout = empty ? 8'h80 : mem[rd_ptr];
    end else if (ctrl_rd) begin
      dout = {4'b0000, enable, overflow, full, empty};
    end
  end

endmodule

// File: tb/tb_audio_sampler.sv
// Self-checking bench for audio_sampler: queue-based reference model, scoreboard of expected read
// data, and a monitor that checks every bus read as it begins.
module tb_audio_sampler;

  localparam int          TD   = 32;
  localparam logic [7:0]  DATA = 8'hDF;
  localparam logic [7:0]  CTRL = 8'hDE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = 8'h00;
  logic       iorq_n = 1'b1;
  logic       rd_n = 1'b1;
  logic       wr_n = 1'b1;
  logic [7:0] d = 8'h00;
  logic [7:0] sample_in = 8'h80;
  logic [7:0] dout;
  logic       oe;

  audio_sampler #(
    .DATA_PORT(DATA),
    .CTRL_PORT(CTRL),
    .TICK_DIV (TD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .iorq_n   (iorq_n),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .d        (d),
    .sample_in(sample_in),
    .dout     (dout),
    .oe       (oe)
  );

  always #5 clk = ~clk;

  // Sample source: random or a fixed value chosen by the stimulus.
  bit         rand_mode = 1'b0;
  logic [7:0] fixed_sample = 8'h80;
  always @(posedge clk) begin
    #2;
    sample_in = rand_mode ? 8'($urandom) : fixed_sample;
  end

  // Reference model: FIFO as a queue, ticks every TD non-reset edges.
  logic [7:0] fifo_m[$];
  bit m_en, m_ov, m_pd, m_pc;
  int n = 0;
  bit cur_d, cur_c, wr_m, tick_m, ov_set;

  always @(posedge clk) begin
    cur_d = !iorq_n && !rd_n && (a == DATA);
    cur_c = !iorq_n && !rd_n && (a == CTRL);
    wr_m  = !iorq_n && !wr_n && (a == CTRL);
    if (rst) begin
      fifo_m.delete();
      m_en = 0; m_ov = 0; m_pd = 0; m_pc = 0; n = 0;
    end else begin
      n = n + 1;
      tick_m = (n % TD) == 0;
      ov_set = 0;
      if (wr_m && d[1]) begin
        fifo_m.delete();
        m_ov = 0;
      end else begin
        if (m_pd && !cur_d && fifo_m.size() > 0) void'(fifo_m.pop_front());
        if (tick_m && m_en) begin
          if (fifo_m.size() < 256) fifo_m.push_back(sample_in);
          else ov_set = 1;
        end
        if (ov_set) m_ov = 1;
        else if (m_pc && !cur_c) m_ov = 0;
      end
      if (wr_m) m_en = d[0];
      m_pd = cur_d;
      m_pc = cur_c;
    end
  end

  function automatic logic [7:0] model_read(input logic [7:0] port);
    if (port == DATA) return (fifo_m.size() == 0) ? 8'h80 : fifo_m[0];
    return {4'b0000, m_en, m_ov, fifo_m.size() == 256, fifo_m.size() == 0};
  endfunction

  // Scoreboard and monitor.
  logic [7:0] exp_q[$];
  string      name_q[$];
  int  errors = 0;
  int  checks = 0;
  bit  prev_dec = 1'b0;
  bit  finish_req = 1'b0;
  bit  dec;
  logic [7:0] exp_v;
  string      exp_n;

  always @(negedge clk) begin
    dec = !iorq_n && !rd_n && (a == DATA || a == CTRL);
    checks++;
    if (oe !== dec) begin
      errors++;
      $display("FAIL oe_decode: oe=%b expected %b (a=%02h)", oe, dec, a);
    end
    if (!dec) begin
      checks++;
      if (dout !== 8'h00) begin
        errors++;
        $display("FAIL idle_dout: dout=%02h expected 00", dout);
      end
    end else if (!prev_dec) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: dout=%02h with no expected entry", dout);
      end else begin
        exp_v = exp_q.pop_front();
        exp_n = name_q.pop_front();
        if (dout !== exp_v) begin
          errors++;
          $display("FAIL %s: dout=%02h expected %02h", exp_n, dout, exp_v);
        end
      end
    end
    prev_dec = dec;
    if (finish_req) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: pending=%0d expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Stimulus tasks: each starts and ends 1 time unit after a rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_after_tick();
    while (n % TD != 0) cyc();
  endtask

  task automatic wait_pre_tick();
    while ((n + 1) % TD != 0) cyc();
  endtask

  task automatic tick_with(input logic [7:0] val);
    wait_pre_tick();
    fixed_sample = val;
    cyc();
  endtask

  task automatic ctrl_write(input logic [7:0] val);
    a = CTRL; d = val; iorq_n = 0; wr_n = 0;
    cyc();
    iorq_n = 1; wr_n = 1;
  endtask

  task automatic expect_push(input logic [7:0] port, input bit use_c, input logic [7:0] cval,
                             input string nm);
    exp_q.push_back(use_c ? cval : model_read(port));
    name_q.push_back(nm);
  endtask

  task automatic do_read(input logic [7:0] port, input int cycles, input bit use_c,
                         input logic [7:0] cval, input string nm);
    expect_push(port, use_c, cval, nm);
    a = port; iorq_n = 0; rd_n = 0;
    repeat (cycles) cyc();
    iorq_n = 1; rd_n = 1;
    cyc();
  endtask

  initial begin
    logic [7:0] addr;
    int op;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    cyc();

    // Post-reset state.
    do_read(CTRL, 1, 1, 8'h01, "reset_status");
    do_read(DATA, 1, 1, 8'h80, "reset_data_empty");

    // Enable and capture three samples.
    sync_after_tick();
    ctrl_write(8'h03);
    tick_with(8'h10);
    tick_with(8'h11);
    tick_with(8'h12);
    do_read(CTRL, 1, 1, 8'h08, "cap_status_nonempty");
    do_read(DATA, 1, 1, 8'h10, "cap_read0");
    do_read(DATA, 1, 1, 8'h11, "cap_read1");
    do_read(DATA, 1, 1, 8'h12, "cap_read2");
    do_read(DATA, 1, 1, 8'h80, "cap_read_empty");
    do_read(CTRL, 1, 1, 8'h09, "cap_status_empty");
    ctrl_write(8'h00);

    // Long strobe pops exactly once.
    sync_after_tick();
    ctrl_write(8'h03);
    tick_with(8'h21);
    tick_with(8'h22);
    ctrl_write(8'h00);
    do_read(DATA, 5, 1, 8'h21, "long_strobe_first");
    do_read(DATA, 1, 1, 8'h22, "long_strobe_second");
    do_read(DATA, 1, 1, 8'h80, "long_strobe_empty");
    do_read(CTRL, 1, 1, 8'h01, "long_strobe_status");

    // Overflow: 257 ticks of A5.
    sync_after_tick();
    ctrl_write(8'h03);
    repeat (257) tick_with(8'hA5);
    do_read(CTRL, 1, 1, 8'h0E, "ovf_status_first");
    do_read(CTRL, 1, 1, 8'h0A, "ovf_status_cleared");
    ctrl_write(8'h00);
    for (int i = 0; i < 256; i++) do_read(DATA, 1, 1, 8'hA5, "ovf_drain");
    do_read(CTRL, 1, 1, 8'h01, "ovf_drained_status");

    // Pop released on the same edge as a tick into a full FIFO.
    rand_mode = 1'b1;
    sync_after_tick();
    ctrl_write(8'h03);
    repeat (256) begin
      wait_pre_tick();
      cyc();
    end
    expect_push(DATA, 0, 8'h00, "simul_first");
    a = DATA; iorq_n = 0; rd_n = 0;
    cyc();
    wait_pre_tick();
    iorq_n = 1; rd_n = 1;
    cyc();
    do_read(CTRL, 1, 1, 8'h0A, "simul_status_full_no_ovf");
    ctrl_write(8'h00);
    for (int i = 0; i < 256; i++) do_read(DATA, 1, 0, 8'h00, "simul_order");
    do_read(CTRL, 1, 1, 8'h01, "simul_drained_status");

    // Clear on a tick cycle drops that sample.
    sync_after_tick();
    ctrl_write(8'h03);
    repeat (7) tick_with(8'h33);
    do_read(CTRL, 1, 1, 8'h08, "clr_pre_status");
    wait_pre_tick();
    ctrl_write(8'h03);
    do_read(CTRL, 1, 1, 8'h09, "clr_on_tick_status");
    do_read(DATA, 1, 1, 8'h80, "clr_on_tick_empty");

    // Reset in the middle of a read.
    expect_push(DATA, 1, 8'h80, "rst_read_start");
    a = DATA; iorq_n = 0; rd_n = 0;
    cyc();
    rst = 1;
    cyc();
    cyc();
    iorq_n = 1; rd_n = 1;
    cyc();
    rst = 0;
    cyc();
    do_read(CTRL, 1, 1, 8'h01, "rst_status");

    // Randomized traffic against the model.
    ctrl_write(8'h01);
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      if (op < 4) begin
        do_read(DATA, $urandom_range(1, 4), 0, 8'h00, "rnd_data");
      end else if (op < 6) begin
        do_read(CTRL, $urandom_range(1, 2), 0, 8'h00, "rnd_status");
      end else if (op == 6) begin
        ctrl_write({6'b0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0});
      end else if (op == 7) begin
        addr = 8'($urandom);
        if (addr == DATA || addr == CTRL) addr = 8'h00;
        a = addr; iorq_n = 0; rd_n = 0;
        cyc();
        iorq_n = 1; rd_n = 1;
        cyc();
      end else begin
        repeat ($urandom_range(1, 12)) cyc();
      end
    end

    repeat (3) cyc();
    finish_req = 1'b1;
  end

endmodule
